// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared definitions for the ALU command controller: frame opcodes, state
// encodings and the ALU function codes common to controller and ALU.
package alu_cmd_ctrl_pkg;

  localparam int         FUN_WIDTH = 4;
  localparam logic [7:0] OPC_OPER  = 8'hCC;
  localparam logic [7:0] OPC_NOOP  = 8'hDD;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_A    = 4'd1,
    GET_B    = 4'd2,
    GET_FUN  = 4'd3,
    ALU_RUN  = 4'd4,
    ALU_WAIT = 4'd5,
    SEND_LO  = 4'd6,
    WAIT_LO  = 4'd7,
    SEND_HI  = 4'd8,
    WAIT_HI  = 4'd9
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_SEND = 2'd1,
    SER_WAIT = 2'd2
  } ser_phase_e;

  localparam logic [FUN_WIDTH-1:0] ALU_ADD   = 4'd0;
  localparam logic [FUN_WIDTH-1:0] ALU_SUB   = 4'd1;
  localparam logic [FUN_WIDTH-1:0] ALU_MUL   = 4'd2;
  localparam logic [FUN_WIDTH-1:0] ALU_DIV   = 4'd3;
  localparam logic [FUN_WIDTH-1:0] ALU_AND   = 4'd4;
  localparam logic [FUN_WIDTH-1:0] ALU_OR    = 4'd5;
  localparam logic [FUN_WIDTH-1:0] ALU_NAND  = 4'd6;
  localparam logic [FUN_WIDTH-1:0] ALU_NOR   = 4'd7;
  localparam logic [FUN_WIDTH-1:0] ALU_XOR   = 4'd8;
  localparam logic [FUN_WIDTH-1:0] ALU_XNOR  = 4'd9;
  localparam logic [FUN_WIDTH-1:0] ALU_CMPEQ = 4'd10;
  localparam logic [FUN_WIDTH-1:0] ALU_CMPGT = 4'd11;
  localparam logic [FUN_WIDTH-1:0] ALU_CMPLT = 4'd12;
  localparam logic [FUN_WIDTH-1:0] ALU_SHR   = 4'd13;
  localparam logic [FUN_WIDTH-1:0] ALU_SHL   = 4'd14;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of the UART-side, ALU-side and status signals around the controller.
// master = controller side, slave = UART/ALU environment side.
interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  import alu_cmd_ctrl_pkg::*;

  localparam int OUT_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_d_vld;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  alu_en;
  logic [OUT_WIDTH-1:0]  alu_out;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_d_vld;
  logic                  tx_busy;
  logic                  ctrl_busy;
  logic                  frm_err;

  modport master (
    input  rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, ctrl_busy, frm_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, ctrl_busy, frm_err
  );

endinterface

// File: rtl/alu_tx_serializer.sv
// Sends a captured result word to the transmitter as two bytes, LSB first,
// each byte strobed only when the transmitter is idle and acked by its busy rise.
module alu_tx_serializer
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [2*DATA_WIDTH-1:0] word_i,
  input  logic                    tx_busy_i,
  output logic [DATA_WIDTH-1:0]   tx_p_data_o,
  output logic                    tx_d_vld_o,
  output logic                    byte_ack_o
);

  localparam int OUT_WIDTH = 2 * DATA_WIDTH;

  ser_phase_e           phase_q, phase_d;
  logic                 hi_q, hi_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= SER_IDLE;
      hi_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    hi_d       = hi_q;
    word_d     = word_q;
    tx_d_vld_o = 1'b0;
    byte_ack_o = 1'b0;
    case (phase_q)
      SER_IDLE: begin
        if (start_i) begin
          word_d  = word_i;
          hi_d    = 1'b0;
          phase_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (!tx_busy_i) begin
          tx_d_vld_o = 1'b1;
          phase_d    = SER_WAIT;
        end
      end
      SER_WAIT: begin
        // The busy rise is the transmitter's acknowledge of the byte just strobed.
        if (tx_busy_i) begin
          byte_ack_o = 1'b1;
          hi_d       = ~hi_q;
          phase_d    = hi_q ? SER_IDLE : SER_SEND;
        end
      end
      default: phase_d = SER_IDLE;
    endcase
  end

  assign tx_p_data_o = hi_q ? word_q[OUT_WIDTH-1:DATA_WIDTH] : word_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU master: assembles CC/DD frames from RX bytes, issues one
// ALU operation per frame and returns the 16-bit result over TX.
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   GET_*    | collecting A, B, FUN bytes
//   ALU_RUN  | single-cycle ALU_EN
//   ALU_WAIT | capture ALU_OUT, flag missing OUT_VALID
//   SEND/WAIT_LO/HI | result byte handshake with transmitter
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = OPC_OPER,
  parameter logic [DATA_WIDTH-1:0] CMD_NOOP   = OPC_NOOP
) (
  input logic             clk,
  input logic             rst_n,
  alu_cmd_ctrl_if.master  bus
);

  ctrl_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  err_q, err_d;
  logic                  ser_start;
  logic                  ser_vld;
  logic                  ser_ack;
  logic [DATA_WIDTH-1:0] ser_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    err_d     = 1'b0;
    ser_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_d_vld) begin
          if (bus.rx_p_data == CMD_OPER)      state_d = GET_A;
          else if (bus.rx_p_data == CMD_NOOP) state_d = GET_FUN;
          else                                err_d   = 1'b1;
        end
      end
      GET_A: begin
        if (bus.rx_d_vld) begin
          a_d     = bus.rx_p_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (bus.rx_d_vld) begin
          b_d     = bus.rx_p_data;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (bus.rx_d_vld) begin
          fun_d   = bus.rx_p_data[FUN_WIDTH-1:0];
          state_d = ALU_RUN;
        end
      end
      ALU_RUN:  state_d = ALU_WAIT;
      // The result is taken whatever OUT_VALID says; a low OUT_VALID only raises FRM_ERR.
      ALU_WAIT: begin
        ser_start = 1'b1;
        state_d   = SEND_LO;
      end
      SEND_LO:  if (ser_vld) state_d = WAIT_LO;
      WAIT_LO:  if (ser_ack) state_d = SEND_HI;
      SEND_HI:  if (ser_vld) state_d = WAIT_HI;
      WAIT_HI:  if (ser_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  alu_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (ser_start),
    .word_i      (bus.alu_out),
    .tx_busy_i   (bus.tx_busy),
    .tx_p_data_o (ser_data),
    .tx_d_vld_o  (ser_vld),
    .byte_ack_o  (ser_ack)
  );

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fun   = fun_q;
  assign bus.alu_en    = (state_q == ALU_RUN);
  assign bus.tx_p_data = ser_data;
  assign bus.tx_d_vld  = ser_vld;
  assign bus.ctrl_busy = (state_q != IDLE);
  assign bus.frm_err   = err_q | ((state_q == ALU_WAIT) & ~bus.out_valid);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: frame-level model of expected ALU issues and
// TX bytes, checked every cycle, plus literal expectations per scenario.
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
  } en_t;

  logic clk;
  logic rst_n;
  logic hold_busy;
  logic ov_kill;
  logic [15:0] alu_out_q;
  logic valid_q;
  int tx_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, en_cnt = 0, vld_cnt = 0, err_cnt = 0, exp_err = 0, busy_cnt = 0;
  int en_cyc = 0, err_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic prev_en = 1'b0, prev_txb = 1'b0, prev_cb = 1'b0;
  logic [7:0] model_a = 8'h00, model_b = 8'h00;
  en_t en_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] tx_log[$];

  alu_cmd_ctrl_if #(.DATA_WIDTH(8)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] f);
    logic [15:0] aw, bw;
    aw = {8'h00, a};
    bw = {8'h00, b};
    case (f)
      ALU_ADD:   return aw + bw;
      ALU_SUB:   return aw - bw;
      ALU_MUL:   return aw * bw;
      ALU_DIV:   return (b != 0) ? aw / bw : 16'h0000;
      ALU_AND:   return {8'h00, a & b};
      ALU_OR:    return {8'h00, a | b};
      ALU_NAND:  return {8'h00, ~(a & b)};
      ALU_NOR:   return {8'h00, ~(a | b)};
      ALU_XOR:   return {8'h00, a ^ b};
      ALU_XNOR:  return {8'h00, ~(a ^ b)};
      ALU_CMPEQ: return {15'h0000, a == b};
      ALU_CMPGT: return {15'h0000, a > b};
      ALU_CMPLT: return {15'h0000, a < b};
      ALU_SHR:   return aw >> 1;
      ALU_SHL:   return aw << 1;
      default:   return 16'h0000;
    endcase
  endfunction

  // Registered ALU: result and valid update on the edge that ends the EN cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= 16'h0000;
      valid_q   <= 1'b0;
    end else if (bus.alu_en) begin
      alu_out_q <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);
      valid_q   <= 1'b1;
    end
  end
  assign bus.alu_out   = alu_out_q;
  assign bus.out_valid = valid_q & ~ov_kill;

  // Transmitter: busy for 10 cycles after each strobe, or held busy on demand.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tx_cnt <= 0;
    else if (bus.tx_d_vld)    tx_cnt <= 10;
    else if (tx_cnt != 0)     tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = hold_busy | (tx_cnt != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    en_t e;
    logic [7:0] eb;
    if (rst_n) begin
      cyc++;
      if (bus.alu_en) begin
        chk("alu_en_width", {31'd0, prev_en}, 0);
        chk("alu_en_expected", {31'd0, en_q.size() != 0}, 1);
        if (en_q.size() != 0) begin
          e = en_q.pop_front();
          chk("alu_a", {24'd0, bus.alu_a}, {24'd0, e.a});
          chk("alu_b", {24'd0, bus.alu_b}, {24'd0, e.b});
          chk("alu_fun", {28'd0, bus.alu_fun}, {28'd0, e.f});
        end
        en_cnt++;
        en_cyc = cyc;
      end
      if (bus.tx_d_vld) begin
        chk("tx_vld_while_busy", {31'd0, bus.tx_busy}, 0);
        chk("tx_expected", {31'd0, tx_q.size() != 0}, 1);
        if (tx_q.size() != 0) begin
          eb = tx_q.pop_front();
          chk("tx_byte", {24'd0, bus.tx_p_data}, {24'd0, eb});
        end
        tx_log.push_back(bus.tx_p_data);
        vld_cnt++;
      end
      if (bus.frm_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (bus.ctrl_busy) busy_cnt++;
      if (bus.tx_busy && !prev_txb) rise_cyc = cyc;
      if (!bus.ctrl_busy && prev_cb) fall_cyc = cyc;
      prev_en  = bus.alu_en;
      prev_txb = bus.tx_busy;
      prev_cb  = bus.ctrl_busy;
    end else begin
      prev_en  = 1'b0;
      prev_txb = 1'b0;
      prev_cb  = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic push_expect(input logic [3:0] f);
    en_t e;
    logic [15:0] r;
    e.a = model_a;
    e.b = model_b;
    e.f = f;
    en_q.push_back(e);
    r = alu_f(model_a, model_b, f);
    tx_q.push_back(r[7:0]);
    tx_q.push_back(r[15:8]);
    if (ov_kill) exp_err++;
  endtask

  task automatic frame_oper(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb);
    model_a = a;
    model_b = b;
    push_expect(fb[3:0]);
    tx_log.delete();
    send_byte(OPC_OPER);
    send_byte(a);
    send_byte(b);
    send_byte(fb);
  endtask

  task automatic frame_noop(input logic [7:0] fb);
    push_expect(fb[3:0]);
    tx_log.delete();
    send_byte(OPC_NOOP);
    send_byte(fb);
  endtask

  task automatic idle_byte(input logic [7:0] b);
    if (b != OPC_OPER && b != OPC_NOOP) exp_err++;
    send_byte(b);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ctrl_busy && n < 400);
    #1;
    chk(nm, {31'd0, bus.ctrl_busy}, 0);
  endtask

  task automatic check_last2(input string nm, input logic [7:0] lo, input logic [7:0] hi);
    chk({nm, "_nbytes"}, tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk({nm, "_lo"}, {24'd0, tx_log[0]}, {24'd0, lo});
      chk({nm, "_hi"}, {24'd0, tx_log[1]}, {24'd0, hi});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_a"},     {24'd0, bus.alu_a}, 0);
    chk({tag, "_alu_b"},     {24'd0, bus.alu_b}, 0);
    chk({tag, "_alu_fun"},   {28'd0, bus.alu_fun}, 0);
    chk({tag, "_alu_en"},    {31'd0, bus.alu_en}, 0);
    chk({tag, "_tx_data"},   {24'd0, bus.tx_p_data}, 0);
    chk({tag, "_tx_vld"},    {31'd0, bus.tx_d_vld}, 0);
    chk({tag, "_ctrl_busy"}, {31'd0, bus.ctrl_busy}, 0);
    chk({tag, "_frm_err"},   {31'd0, bus.frm_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, err0, bc0, vld0;
    rst_n         = 1'b0;
    hold_busy     = 1'b0;
    ov_kill       = 1'b0;
    bus.rx_p_data = 8'h00;
    bus.rx_d_vld  = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("rst");

    chk("model_add",  {16'd0, alu_f(8'h05, 8'h03, 4'h0)}, 32'h0008);
    chk("model_mul",  {16'd0, alu_f(8'hFF, 8'hFF, 4'h2)}, 32'hFE01);
    chk("model_sub",  {16'd0, alu_f(8'hFF, 8'hFF, 4'h1)}, 32'h0000);
    chk("model_cmp",  {16'd0, alu_f(8'h02, 8'h02, 4'hA)}, 32'h0001);
    chk("model_shl",  {16'd0, alu_f(8'h01, 8'h01, 4'hE)}, 32'h0002);
    chk("model_xnor", {16'd0, alu_f(8'h00, 8'h00, 4'h9)}, 32'h00FF);
    chk("model_funf", {16'd0, alu_f(8'h12, 8'h34, 4'hF)}, 32'h0000);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // CC,05,03,00 -> 0x08, 0x00
    en0 = en_cnt;
    frame_oper(8'h05, 8'h03, 8'h00);
    wait_idle("f1_idle");
    chk("f1_en_pulses", en_cnt - en0, 1);
    check_last2("f1", 8'h08, 8'h00);
    chk("f1_busy_fall", fall_cyc, rise_cyc + 1);

    // CC,FF,FF,02 then DD,01 reusing A/B
    frame_oper(8'hFF, 8'hFF, 8'h02);
    wait_idle("f2_idle");
    check_last2("f2", 8'h01, 8'hFE);
    frame_noop(8'h01);
    wait_idle("f3_idle");
    check_last2("f3", 8'h00, 8'h00);

    // Unknown opcode in IDLE
    en0  = en_cnt;
    err0 = err_cnt;
    bc0  = busy_cnt;
    idle_byte(8'h55);
    repeat (6) @(posedge clk);
    #1;
    chk("bad_err_pulses", err_cnt - err0, 1);
    chk("bad_no_en", en_cnt - en0, 0);
    chk("bad_no_busy", busy_cnt - bc0, 0);
    frame_oper(8'h03, 8'h04, 8'hF0);
    wait_idle("f4_idle");
    check_last2("f4", 8'h07, 8'h00);

    // OUT_VALID low: error raised in ALU_WAIT, result still sent
    ov_kill = 1'b1;
    err0 = err_cnt;
    frame_oper(8'h02, 8'h02, 8'h0A);
    wait_idle("f5_idle");
    ov_kill = 1'b0;
    chk("ov_err_pulses", err_cnt - err0, 1);
    chk("ov_err_cycle", err_cyc, en_cyc + 1);
    check_last2("f5", 8'h01, 8'h00);

    // Function 0xF passes through; ALU returns zero
    frame_oper(8'h12, 8'h34, 8'h0F);
    wait_idle("f6_idle");
    check_last2("f6", 8'h00, 8'h00);

    // Transmitter held busy; stray RX bytes dropped
    hold_busy = 1'b1;
    vld0 = vld_cnt;
    err0 = err_cnt;
    frame_oper(8'h0A, 8'h05, 8'h01);
    send_byte(8'h55);
    send_byte(8'hCC);
    repeat (50) @(posedge clk);
    #1;
    chk("hold_no_vld", vld_cnt - vld0, 0);
    chk("hold_busy_ctrl", {31'd0, bus.ctrl_busy}, 1);
    hold_busy = 1'b0;
    wait_idle("f7_idle");
    chk("hold_vld_count", vld_cnt - vld0, 2);
    chk("hold_no_err", err_cnt - err0, 0);
    check_last2("f7", 8'h05, 8'h00);

    // Reset mid-frame
    tx_log.delete();
    send_byte(OPC_OPER);
    send_byte(8'h07);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_a = 8'h00;
    model_b = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_noop(8'h09);
    wait_idle("f8_idle");
    check_last2("f8", 8'hFF, 8'h00);
    frame_oper(8'h01, 8'h01, 8'h0E);
    wait_idle("f9_idle");
    check_last2("f9", 8'h02, 8'h00);

    repeat (5) @(posedge clk);
    #1;
    chk("end_tx_pending", tx_q.size(), 0);
    chk("end_en_pending", en_q.size(), 0);
    chk("end_err_total", err_cnt, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command-side master for the system ALU. It receives a byte stream from the UART receiver and assembles command frames. It drives the ALU operand, function and enable inputs, captures the registered 16-bit result, and returns it as two bytes to the UART transmitter. It is the issuing and consuming end of the ALU's EN / ALU_FUN / ALU_OUT / OUT_VALID interface.

Parameters:
DATA_WIDTH, 8, byte and operand width (A, B, RX/TX data).
OUT_WIDTH, 2*DATA_WIDTH, ALU result width; sent as 2 bytes, LSB first.
CMD_OPER, 8'hCC, frame opcode: A, B, FUN follow.
CMD_NOOP, 8'hDD, frame opcode: FUN only, reuse stored A/B.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_A  out  DATA_WIDTH  operand A, registered
ALU_B  out  DATA_WIDTH  operand B, registered
ALU_FUN  out  4  function code, registered
ALU_EN  out  1  one-cycle ALU enable
ALU_OUT  in  OUT_WIDTH  ALU registered result
OUT_VALID  in  1  ALU registered valid
TX_P_DATA  out  DATA_WIDTH  byte to transmitter
TX_D_VLD  out  1  one-cycle send strobe
TX_BUSY  in  1  transmitter busy
CTRL_BUSY  out  1  high in any state except IDLE
FRM_ERR  out  1  one-cycle pulse on an unknown opcode, or on a missing OUT_VALID

Behaviour:
- Reset: all outputs 0. Stored A, B, FUN and result registers are 0. State is IDLE.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- IDLE, on RX_D_VLD:
  - byte == CMD_OPER -> GET_A.
  - byte == CMD_NOOP -> GET_FUN.
  - any other byte -> FRM_ERR pulse next cycle, stay in IDLE.
- GET_A / GET_B: on RX_D_VLD, latch the byte into ALU_A / ALU_B, then advance. Without RX_D_VLD, hold state indefinitely; there is no timeout.
- GET_FUN: on RX_D_VLD, latch RX_P_DATA[3:0] into ALU_FUN (upper bits ignored), then go to ALU_RUN.
- ALU_RUN: ALU_EN = 1 for exactly this one cycle, then go to ALU_WAIT.
  - ALU_A, ALU_B and ALU_FUN are stable from the cycle before ALU_EN until the frame completes.
- ALU_WAIT: exactly one cycle after the ALU_EN cycle, the ALU registers have updated.
  - Sample ALU_OUT into the result register.
  - If OUT_VALID == 0, pulse FRM_ERR and still send the result.
  - OUT_VALID is level-held by the ALU between enables; never use an edge of it.
- Send sequence, one byte per stage, each stage identical:
  - SEND_LO: when TX_BUSY == 0, TX_P_DATA = result[7:0] and TX_D_VLD = 1 for one cycle, then go to WAIT_LO.
  - WAIT_LO: wait until TX_BUSY == 1, then go to SEND_HI.
  - SEND_HI / WAIT_HI: same handshake with result[15:8]. WAIT_HI returns to IDLE when TX_BUSY == 1.
  - Any TX wait may last indefinitely.
- Bytes arriving on RX_D_VLD outside IDLE/GET_* states are dropped silently; no error.
- Function code 4'hF is passed through unchanged; the ALU returns 0, so 0x00 0x00 is sent.
- CMD_NOOP with no prior CMD_OPER since reset uses A = B = 0.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. A partial frame is discarded; no TX strobe follows reset release.
- Throughput: the controller does not accept a new frame until WAIT_HI exits. There is no internal command queue.

Decomposition:
- Shared package:
  - state encoding enum (binary, 4 bits);
  - CMD_OPER / CMD_NOOP constants;
  - ALU function code constants (ADD = 0 … SHL = 14), shared with the ALU.
- One natural sub-module, alu_tx_serializer: the SEND/WAIT byte handshake, instantiated once and fed a 16-bit word plus a start strobe. The FSM stays in the top module.

Test Plan:
- Frame CC,05,03,00 with TX_BUSY modelled as 10 cycles busy per byte:
  - ALU_EN is a single pulse, with A = 05, B = 03, FUN = 0;
  - TX emits 0x08 then 0x00;
  - CTRL_BUSY falls after the second TX_BUSY rise.
- Frame CC,FF,FF,02, then DD,01:
  - first frame sends 0x01, 0xFE (product 0xFE01);
  - the DD frame reuses A/B, computes FF-FF and sends 0x00, 0x00.
- Byte 0x55 in IDLE: FRM_ERR pulses once, no ALU_EN, state stays IDLE. A following CC frame processes normally.
- OUT_VALID tied 0 during frame CC,02,02,0A: FRM_ERR pulses in ALU_WAIT; bytes 0x01, 0x00 are still sent.
- TX_BUSY held 1 for 50 cycles before SEND_LO: TX_D_VLD stays 0 until TX_BUSY drops, then pulses exactly once. Extra RX bytes arriving during this time are ignored.
- Reset asserted after CC,07 is received: all outputs are 0 immediately. After release, frame CC,01,01,0E is processed correctly: A<<1 = 0x0002, sent as 0x02, 0x00.
